// File: rtl/sccb_config_seq.sv
// SCCB camera configuration sequencer: walks a {reg_addr, reg_data} ROM and
// issues one three-byte write per entry through a byte-level I2C master.
module sccb_config_seq #(
  parameter int          ADDR_W       = 8,
  parameter int          ROM_DEPTH    = 76,
  parameter logic [7:0]  SLV_ADDR     = 8'h42,
  parameter int          MAX_RETRY    = 3,
  parameter int          TICKS_PER_MS = 100_000,
  parameter int          GAP_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              i2c_en,
  output logic              i2c_start,
  output logic              i2c_stop,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  input  logic              ack_error,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        retry_cnt
);

  localparam int DLY_W = $clog2(255 * TICKS_PER_MS + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DLY_W-1:0]  TICKS     = DLY_W'(TICKS_PER_MS);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(ROM_DEPTH);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_START   = 4'd3;
  localparam logic [3:0] S_SLV     = 4'd4;
  localparam logic [3:0] S_REG     = 4'd5;
  localparam logic [3:0] S_DATA    = 4'd6;
  localparam logic [3:0] S_GAP     = 4'd7;
  localparam logic [3:0] S_DELAY   = 4'd8;
  localparam logic [3:0] S_RECOVER = 4'd9;
  localparam logic [3:0] S_FINISH  = 4'd10;

  logic [3:0]       state;
  logic [7:0]       reg_byte;
  logic [7:0]       data_byte;
  logic [DLY_W-1:0] delay_cnt;
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      retry_cnt <= 2'd0;
      err_addr  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      delay_cnt <= '0;
      reg_byte  <= 8'h00;
      data_byte <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            retry_cnt <= 2'd0;
            rom_addr  <= '0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          // The depth check stops the walk before rom_addr can ever pass ROM_DEPTH.
          if (rom_data == 16'hFFFF || rom_addr == END_ADDR) begin
            state <= S_FINISH;
          end else if (rom_data[15:8] == 8'hFE) begin
            delay_cnt <= (rom_data[7:0] == 8'd0) ? DLY_W'(1)
                                                 : DLY_W'(rom_data[7:0]) * TICKS;
            state     <= S_DELAY;
          end else begin
            reg_byte  <= rom_data[15:8];
            data_byte <= rom_data[7:0];
            state     <= S_START;
          end
        end
        S_START: state <= S_SLV;
        S_SLV: begin
          if (ack_error)    state <= S_RECOVER;
          else if (tx_done) state <= S_REG;
        end
        S_REG: begin
          if (ack_error)    state <= S_RECOVER;
          else if (tx_done) state <= S_DATA;
        end
        S_DATA: begin
          if (ack_error)    state <= S_RECOVER;
          else if (tx_done) state <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            rom_addr  <= rom_addr + ADDR_W'(1);
            retry_cnt <= 2'd0;
            state     <= S_FETCH;
          end
        end
        S_DELAY: begin
          if (delay_cnt <= DLY_W'(1)) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state    <= S_FETCH;
          end else begin
            delay_cnt <= delay_cnt - DLY_W'(1);
          end
        end
        S_RECOVER: begin
          if (gap_cnt == GAP_LAST) begin
            if (int'(retry_cnt) < MAX_RETRY) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= S_START;
            end else begin
              error    <= 1'b1;
              err_addr <= rom_addr;
              state    <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shared idle timer for GAP and RECOVER; it sits at zero in every other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if ((state == S_GAP || state == S_RECOVER) && gap_cnt != GAP_LAST) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_START, S_SLV: tx_data = SLV_ADDR;
      S_REG:          tx_data = reg_byte;
      S_DATA:         tx_data = data_byte;
      default:        tx_data = 8'h00;
    endcase
  end

  // Bus controls decode straight from state so a reset drops them in the same cycle.
  assign i2c_en    = (state == S_START) || (state == S_SLV) ||
                     (state == S_REG)   || (state == S_DATA);
  assign i2c_start = (state == S_START);
  assign i2c_stop  = (state == S_DATA);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: a transaction-level model predicts every START
// and byte the sequencer must produce; a responder/monitor checks them live.
module tb_sccb_config_seq;

  localparam int         ADDR_W    = 8;
  localparam int         ROM_DEPTH = 6;
  localparam int         MAX_RETRY = 3;
  localparam int         TICKS     = 10;
  localparam int         GAP       = 4;
  localparam logic [7:0] SLV       = 8'h42;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              i2c_en, i2c_start, i2c_stop;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic              ack_error = 1'b0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] err_addr;
  logic [1:0]        retry_cnt;

  sccb_config_seq #(
    .ADDR_W(ADDR_W), .ROM_DEPTH(ROM_DEPTH), .SLV_ADDR(SLV),
    .MAX_RETRY(MAX_RETRY), .TICKS_PER_MS(TICKS), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_en(i2c_en), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .tx_data(tx_data), .tx_done(tx_done), .ack_error(ack_error),
    .busy(busy), .done(done), .error(error),
    .err_addr(err_addr), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:15];
  always @(posedge clk) rom_data <= rom[rom_addr[3:0]];

  typedef struct {
    bit         is_start;
    logic [7:0] value;
    bit         nack;
    int         phase;
    int         low_run;
    int         retry;
    int         addr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  bit         nack_tab [16][4][3];
  int         exp_final_addr;
  bit         exp_error;
  int         exp_err_addr;

  int         total = 0;
  int         bad = 0;
  int         low_cnt = 0;
  int         lat = -1;
  int         obs_starts = 0;
  logic [7:0] obs_bytes[$];
  int         obs_low[$];
  int         obs_retry[$];
  logic [7:0] lit_basic [6] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h01};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %s", name, what);
  endtask

  // Whole-run prediction from the ROM contents and the planned NACK pattern.
  task automatic build_expect();
    int  e, pend, n;
    bit  ok;
    ev_t ev;
    exp_q.delete();
    exp_error = 0;
    exp_err_addr = 0;
    e = 0;
    pend = 2;
    ok = 1;
    while (1) begin
      if (e == ROM_DEPTH || rom[e] == 16'hFFFF) break;
      if (rom[e][15:8] == 8'hFE) begin
        n = int'(rom[e][7:0]) * TICKS;
        if (n == 0) n = 1;
        pend += n + 2;
        e++;
        continue;
      end
      for (int a = 0; a <= MAX_RETRY; a++) begin
        ev = '{is_start: 1, value: SLV, nack: 0, phase: 0, low_run: pend, retry: a, addr: e};
        exp_q.push_back(ev);
        ok = 1;
        for (int b = 0; b < 3; b++) begin
          ev.is_start = 0;
          ev.phase    = b;
          ev.value    = (b == 0) ? SLV : (b == 1) ? rom[e][15:8] : rom[e][7:0];
          ev.nack     = nack_tab[e][a][b];
          exp_q.push_back(ev);
          if (ev.nack) begin
            ok = 0;
            break;
          end
        end
        if (ok) break;
        pend = GAP;
      end
      if (!ok) begin
        exp_error = 1;
        exp_err_addr = e;
        break;
      end
      pend = GAP + 2;
      e++;
    end
    exp_final_addr = e;
  endtask

  // Byte-level I2C responder and the single per-cycle compare process.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      tx_done = 1'b0;
      ack_error = 1'b0;
      if (!reset_n) begin
        lat = -1;
        low_cnt = 0;
        continue;
      end
      check_output("bus_flags", {29'd0, i2c_start & ~i2c_en, i2c_stop & ~i2c_en, i2c_en & ~busy}, 32'd0);
      if (start && !busy) begin
        low_cnt = 0;
      end else if (!i2c_en) begin
        low_cnt++;
      end else if (i2c_start) begin
        obs_starts++;
        obs_low.push_back(low_cnt);
        obs_retry.push_back(int'(retry_cnt));
        if (exp_q.size() == 0 || !exp_q[0].is_start) begin
          fail_evt("start_order", "START pulse, required a data byte or nothing");
        end else begin
          mon_ev = exp_q.pop_front();
          check_output("start_low_run", low_cnt, mon_ev.low_run);
          check_output("start_retry", {30'd0, retry_cnt}, mon_ev.retry);
          check_output("start_addr", {24'd0, rom_addr}, mon_ev.addr);
          check_output("start_tx_data", {24'd0, tx_data}, {24'd0, SLV});
        end
        low_cnt = 0;
        lat = -1;
      end else begin
        low_cnt = 0;
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          lat = -1;
          obs_bytes.push_back(tx_data);
          if (exp_q.size() == 0 || exp_q[0].is_start) begin
            fail_evt("byte_order", "data byte, required a START or nothing");
            tx_done = 1'b1;
          end else begin
            mon_ev = exp_q.pop_front();
            check_output("byte_value", {24'd0, tx_data}, {24'd0, mon_ev.value});
            check_output("stop_flag", {31'd0, i2c_stop}, (mon_ev.phase == 2) ? 32'd1 : 32'd0);
            if (mon_ev.nack) begin
              ack_error = 1'b1;
              tx_done = 1'($urandom_range(0, 1));
            end else begin
              tx_done = 1'b1;
            end
          end
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic clear_nacks();
    for (int i = 0; i < 16; i++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 3; b++) nack_tab[i][a][b] = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_flags"}, {26'd0, i2c_en, i2c_start, i2c_stop, busy, done, error}, 32'd0);
    check_output({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check_output({tag, "_rom_addr"}, {24'd0, rom_addr}, 32'd0);
    check_output({tag, "_retry"}, {30'd0, retry_cnt}, 32'd0);
    check_output({tag, "_err_addr"}, {24'd0, err_addr}, 32'd0);
  endtask

  task automatic apply_stimulus();
    build_expect();
    obs_starts = 0;
    obs_bytes.delete();
    obs_low.delete();
    obs_retry.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check_output("kick_busy", {31'd0, busy}, 32'd1);
    check_output("kick_clears", {30'd0, done, error}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (poke) start = (cyc == 30);
    end
    start = 1'b0;
    if (cyc >= 5000) fail_evt({tag, "_timeout"}, "no done within 5000 cycles, required done");
    #2;
    check_output({tag, "_done"}, {31'd0, done}, 32'd1);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_error"}, {31'd0, error}, {31'd0, exp_error});
    check_output({tag, "_end_addr"}, {24'd0, rom_addr}, exp_final_addr);
    check_output({tag, "_events_left"}, exp_q.size(), 32'd0);
    if (exp_error) check_output({tag, "_err_addr"}, {24'd0, err_addr}, exp_err_addr);
    else           check_output({tag, "_retry_end"}, {30'd0, retry_cnt}, 32'd0);
  endtask

  task automatic run_seq(input string tag, input bit poke);
    apply_stimulus();
    wait_done(tag, poke);
  endtask

  initial begin
    int k, cyc;
    clear_rom();
    clear_nacks();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 check_reset_values("por");
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #2 check_output("no_auto_run", {31'd0, busy}, 32'd0);

    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    run_seq("basic", 0);
    check_output("basic_starts", obs_starts, 32'd2);
    check_output("basic_nbytes", obs_bytes.size(), 32'd6);
    for (int i = 0; i < 6 && i < obs_bytes.size(); i++)
      check_output("basic_byte", {24'd0, obs_bytes[i]}, {24'd0, lit_basic[i]});
    check_output("basic_last_addr", {24'd0, rom_addr}, 32'd2);

    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFE02; rom[2] = 16'h1355;
    run_seq("delay2", 0);
    check_output("delay2_starts", obs_starts, 32'd2);
    if (obs_low.size() > 1) check_output("delay2_idle", obs_low[1], 32'd28);
    else fail_evt("delay2_idle", "fewer than 2 STARTs, required 2");

    clear_rom();
    rom[0] = 16'hFE00; rom[1] = 16'h1234;
    run_seq("delay0", 0);
    if (obs_low.size() > 0) check_output("delay0_idle", obs_low[0], 32'd5);
    else fail_evt("delay0_idle", "no START, required 1");

    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    nack_tab[0][0][1] = 1; nack_tab[0][1][1] = 1;
    run_seq("retry", 0);
    check_output("retry_starts", obs_starts, 32'd4);
    if (obs_retry.size() == 4) begin
      check_output("retry_third", obs_retry[2], 32'd2);
      check_output("retry_next", obs_retry[3], 32'd0);
    end else fail_evt("retry_count", "wrong START count, required 4");

    clear_nacks();
    for (int a = 0; a < 4; a++) nack_tab[0][a][0] = 1;
    run_seq("giveup", 0);
    check_output("giveup_starts", obs_starts, 32'd4);
    check_output("giveup_err", {30'd0, error, done}, 32'd3);
    check_output("giveup_err_addr", {24'd0, err_addr}, 32'd0);

    clear_nacks();
    for (int i = 0; i < 16; i++) rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
    run_seq("depth", 1);
    check_output("depth_starts", obs_starts, 32'd6);
    check_output("depth_last_addr", {24'd0, rom_addr}, 32'd6);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        k = $urandom_range(0, 9);
        if (k == 0)      rom[i] = 16'hFFFF;
        else if (k == 1) rom[i] = {8'hFE, 8'($urandom_range(0, 2))};
        else             rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 3; b++) nack_tab[i][a][b] = ($urandom_range(0, 5) == 0);
      end
      run_seq("rand", r[0]);
    end

    clear_rom();
    clear_nacks();
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1322;
    apply_stimulus();
    cyc = 0;
    while (!(rom_addr == 8'd1 && i2c_en && tx_data == 8'h11) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) fail_evt("reg1_wait", "no REG byte of entry 1, required one");
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #2 check_output("post_reset_idle", {31'd0, busy}, 32'd0);
    run_seq("replay", 0);
    check_output("replay_starts", obs_starts, 32'd3);
    if (obs_bytes.size() >= 3)
      for (int i = 0; i < 3; i++)
        check_output("replay_byte", {24'd0, obs_bytes[i]}, {24'd0, lit_basic[i]});
    else fail_evt("replay_bytes", "fewer than 3 bytes, required at least 3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
